// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin arbiter that hands a shared up-counter to one requester at a
//   time. The owner's terminal value is latched at grant; the counter steps
//   0..len, then a one-cycle done pulse is issued before the grant drops.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    shared counter width in bits
//
// Ports
//   clock    input   rising-edge clock
//   reset    input   asynchronous active-low reset
//   i_Req    input   [NUM_REQ]        level requests
//   i_Len    input   [NUM_REQ*WIDTH]  per-requester terminal values, slice k at [k*WIDTH +: WIDTH]
//   o_Grant  output  [NUM_REQ]        one-hot grant of the current owner, or zero
//   o_Busy   output                   high while any grant is active
//   o_Done   output  [NUM_REQ]        one-hot single-cycle completion pulse
//   o_Count  output  [WIDTH]          current shared counter value
//
// Configuration
//   COUNTER_ARBITER_ABORT_EN  when defined, the owner dropping its request during
//                             counting aborts the operation without a done pulse.
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       i_Req,
    input  logic [NUM_REQ*WIDTH-1:0] i_Len,
    output logic [NUM_REQ-1:0]       o_Grant,
    output logic                     o_Busy,
    output logic [NUM_REQ-1:0]       o_Done,
    output logic [WIDTH-1:0]         o_Count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   len_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [WIDTH-1:0]   pick_len;
    logic [IDX_W-1:0]   next_ptr;

    // Scan requests starting at ptr_q, wrapping, and take the first one found.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_found && i_Req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot = NUM_REQ'(1) << pick_idx;
        pick_len    = i_Len[int'(pick_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (pick_found) begin
                        grant_q <= pick_onehot;
                        owner_q <= pick_idx;
                        len_q   <= pick_len;
                        count_q <= '0;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
`ifdef COUNTER_ARBITER_ABORT_EN
                    if (!i_Req[owner_q]) begin
                        // Owner withdrew: release without a done pulse.
                        grant_q <= '0;
                        count_q <= '0;
                        ptr_q   <= next_ptr;
                        state_q <= IDLE;
                    end else
`endif
                    if (count_q == len_q) begin
                        // Counter holds at len for the done cycle.
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    count_q <= '0;
                    ptr_q   <= next_ptr;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    count_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_Grant = grant_q;
    assign o_Busy  = |grant_q;
    assign o_Done  = done_q;
    assign o_Count = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] len;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         count;

    int n_checks = 0;
    int n_fail   = 0;

    counter_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_Req   (req),
        .i_Len   (len),
        .o_Grant (grant),
        .o_Busy  (busy),
        .o_Done  (done),
        .o_Count (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        len   = '0;
        #12;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done got %b want 0000", done); end
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL idle_no_req got %b want 0000", grant); end
    endtask

    // Len0=3: five granted cycles with count 0,1,2,3,3 and done in the last.
    task automatic test_single();
        logic [7:0] exp_cnt [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
        do_reset();
        len[7:0] = 8'd3;
        req      = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant[%0d] got %b want 0001", k, grant); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d] got %b want 1", k, busy); end
            n_checks++; if (count !== exp_cnt[k]) begin n_fail++; $display("FAIL single_count[%0d] got %0d want %0d", k, count, exp_cnt[k]); end
            n_checks++; if (done !== ((k == 4) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_done[%0d] got %b", k, done); end
        end
        req = '0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_after_busy got %b want 0", busy); end
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL single_after_count got %0d want 0", count); end
        n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_after_done got %b want 0000", done); end
    endtask

    // All four requesting with Len=0: 3-cycle slots (count, done, idle).
    task automatic test_round_robin();
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        len = '0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (grant !== order[k]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", k, grant, order[k]); end
            n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rr_count_done[%0d] got %b want 0000", k, done); end
            tick();
            n_checks++; if (done !== order[k]) begin n_fail++; $display("FAIL rr_done[%0d] got %b want %b", k, done, order[k]); end
            tick();
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_idle[%0d] got %b want 0000", k, grant); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_boundaries();
        do_reset();
        // Len 0: one COUNT cycle, then done.
        len[7:0] = 8'd0;
        req      = 4'b0001;
        tick();
        n_checks++; if (grant !== 4'b0001 || done !== 4'b0000) begin n_fail++; $display("FAIL len0_count got g=%b d=%b want g=0001 d=0000", grant, done); end
        tick();
        n_checks++; if (done !== 4'b0001 || count !== 8'd0) begin n_fail++; $display("FAIL len0_done got d=%b c=%0d want d=0001 c=0", done, count); end
        req = '0;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL len0_idle got %b want 0000", grant); end
        // Len 255: 256 COUNT cycles, no wrap before the match.
        len[7:0] = 8'd255;
        req      = 4'b0001;
        tick();
        n_checks++; if (grant !== 4'b0001 || count !== 8'd0) begin n_fail++; $display("FAIL max_start got g=%b c=%0d", grant, count); end
        for (int k = 1; k < 256; k++) begin
            tick();
            n_checks++; if (count !== 8'(k) || done !== 4'b0000) begin n_fail++; $display("FAIL max_count[%0d] got c=%0d d=%b", k, count, done); end
        end
        tick();
        n_checks++; if (done !== 4'b0001 || count !== 8'd255 || grant !== 4'b0001) begin n_fail++; $display("FAIL max_done got d=%b c=%0d g=%b want 0001/255/0001", done, count, grant); end
        req = '0;
        tick();
        n_checks++; if (busy !== 1'b0 || count !== 8'd0) begin n_fail++; $display("FAIL max_after got b=%b c=%0d want 0/0", busy, count); end
    endtask

    task automatic test_len_change();
        do_reset();
        len[7:0] = 8'd5;
        req      = 4'b0001;
        tick();
        len[7:0] = 8'd1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++; if (count !== 8'(k) || done !== 4'b0000) begin n_fail++; $display("FAIL lenchg_count[%0d] got c=%0d d=%b", k, count, done); end
        end
        tick();
        n_checks++; if (done !== 4'b0001 || count !== 8'd5) begin n_fail++; $display("FAIL lenchg_done got d=%b c=%0d want 0001/5", done, count); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        len[7:0] = 8'd5;
        req      = 4'b0001;
        tick();
        tick();
        tick();
        n_checks++; if (count !== 8'd2) begin n_fail++; $display("FAIL mid_pre_count got %0d want 2", count); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || count !== 8'd0) begin n_fail++; $display("FAIL mid_async got g=%b b=%b d=%b c=%0d want all 0", grant, busy, done, count); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++; if (done !== 4'b0000 || grant !== 4'b0000) begin n_fail++; $display("FAIL mid_held[%0d] got d=%b g=%b", k, done, grant); end
        end
        // Requester 0 owned before reset; ptr must restart at 0, not owner+1.
        reset = 1'b1;
        req   = 4'b1001;
        len   = '0;
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got %b want 0001", grant); end
        req = '0;
        do_reset();
        req = 4'b0100;
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL mid_grant_0100 got %b want 0100", grant); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        len[7:0] = 8'd4;
        req      = 4'b0001;
        tick();
        tick();
        n_checks++; if (count !== 8'd1) begin n_fail++; $display("FAIL abort_pre got %0d want 1", count); end
        req = '0;
`ifdef COUNTER_ARBITER_ABORT_EN
        tick();
        n_checks++; if (grant !== 4'b0000 || done !== 4'b0000 || count !== 8'd0) begin n_fail++; $display("FAIL abort_exit got g=%b d=%b c=%0d want 0/0/0", grant, done, count); end
        tick();
        n_checks++; if (done !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_after got d=%b b=%b", done, busy); end
`else
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_checks++; if (count !== 8'(k) || grant !== 4'b0001) begin n_fail++; $display("FAIL noabort_count[%0d] got c=%0d g=%b", k, count, grant); end
        end
        tick();
        n_checks++; if (done !== 4'b0001 || count !== 8'd4) begin n_fail++; $display("FAIL noabort_done got d=%b c=%0d want 0001/4", done, count); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noabort_after got %b want 0", busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundaries();
        test_len_change();
        test_reset_mid();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
